// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings and the 2-bit branch counter helpers used by
// the fetch-stage next-PC predictor.
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] J_YES    = 4'h0;
  localparam logic [3:0] J_LAST   = 4'h6;

  typedef enum logic [1:0] {
    BHT_STRONG_NT = 2'b00,
    BHT_WEAK_NT   = 2'b01,
    BHT_WEAK_T    = 2'b10,
    BHT_STRONG_T  = 2'b11
  } bht_state_e;

  localparam logic [1:0] BHT_INIT = 2'b10;

  function automatic logic [1:0] bht_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    nxt = cur;
    if (taken && cur != BHT_STRONG_T)
      nxt = cur + 2'd1;
    else if (!taken && cur != BHT_STRONG_NT)
      nxt = cur - 2'd1;
    return nxt;
  endfunction

  function automatic logic bht_predicts_taken(input logic [1:0] cur);
    return cur[1];
  endfunction

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: push overwrites the oldest entry when full,
// flush empties it without clearing the storage.
module ras_stack #(
  parameter int RAS_DEPTH = 8,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [ADDR_W-1:0] din,
  output logic [ADDR_W-1:0] top,
  output logic              empty
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ADDR_W-1:0] mem [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr;
  logic [CNT_W-1:0]  count;

  assign empty = (count == '0);
  // ptr points at the next free slot; the wrap of ptr-1 is the modulo.
  assign top   = mem[ptr - 1'b1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr   <= '0;
      count <= '0;
    end else if (flush) begin
      ptr   <= '0;
      count <= '0;
    end else if (push) begin
      ptr <= ptr + 1'b1;
      if (count != CNT_W'(RAS_DEPTH))
        count <= count + 1'b1;
    end else if (pop && !empty) begin
      ptr   <= ptr - 1'b1;
      count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && push)
      mem[ptr] <= din;
  end

endmodule

// File: rtl/branch_pc_predict.sv
// Y86-64 fetch-stage next-PC predictor: bimodal BHT for jXX, return stack
// for call/ret, and a saturating misprediction counter.
module branch_pc_predict
  import y86_pkg::*;
#(
  parameter int ADDR_W      = 64,
  parameter int BHT_ENTRIES = 16,
  parameter int RAS_DEPTH   = 8,
  parameter int PRED_MODE   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_valid,
  input  logic [3:0]        f_icode,
  input  logic [3:0]        f_ifun,
  input  logic [ADDR_W-1:0] f_pc,
  input  logic [ADDR_W-1:0] f_valC,
  input  logic [ADDR_W-1:0] f_valP,
  output logic [ADDR_W-1:0] predPC,
  output logic              pred_taken,
  output logic              ras_empty_ret,
  input  logic              e_valid,
  input  logic [3:0]        e_icode,
  input  logic [3:0]        e_ifun,
  input  logic [ADDR_W-1:0] e_pc,
  input  logic              e_taken,
  input  logic              e_mispredict,
  input  logic              ras_flush,
  output logic [31:0]       mispred_cnt
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]        bht [BHT_ENTRIES];
  logic [IDX_W-1:0]  f_idx;
  logic [IDX_W-1:0]  e_idx;
  logic              bht_upd;
  logic              ras_push;
  logic              ras_pop;
  logic [ADDR_W-1:0] ras_top;
  logic              ras_empty;
  logic              cond_taken;
  logic              unused_pc_hi;

  // Y86 instructions are byte-aligned, so the index starts at bit 0.
  assign f_idx        = f_pc[IDX_W-1:0];
  assign e_idx        = e_pc[IDX_W-1:0];
  assign unused_pc_hi = ^{f_pc[ADDR_W-1:IDX_W], e_pc[ADDR_W-1:IDX_W]};

  assign cond_taken = (PRED_MODE == 0) || bht_predicts_taken(bht[f_idx]);
  assign bht_upd    = e_valid && (e_icode == I_JXX) && (e_ifun != J_YES);
  assign ras_push   = f_valid && (f_icode == I_CALL);
  assign ras_pop    = f_valid && (f_icode == I_RET);

  ras_stack #(
    .RAS_DEPTH (RAS_DEPTH),
    .ADDR_W    (ADDR_W)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ras_push),
    .pop   (ras_pop),
    .flush (ras_flush),
    .din   (f_valP),
    .top   (ras_top),
    .empty (ras_empty)
  );

  always_comb begin
    predPC        = f_valP;
    pred_taken    = 1'b0;
    ras_empty_ret = 1'b0;
    case (f_icode)
      I_JXX: begin
        if (f_ifun == J_YES) begin
          predPC     = f_valC;
          pred_taken = 1'b1;
        end else if (f_ifun <= J_LAST && cond_taken) begin
          predPC     = f_valC;
          pred_taken = 1'b1;
        end
      end
      I_CALL: predPC = f_valC;
      I_RET: begin
        if (!ras_empty)
          predPC = ras_top;
        else
          ras_empty_ret = 1'b1;
      end
      default: predPC = f_valP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++)
        bht[i] <= BHT_INIT;
    end else if (bht_upd) begin
      bht[e_idx] <= bht_next(bht[e_idx], e_taken);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      mispred_cnt <= '0;
    else if (e_valid && e_mispredict && mispred_cnt != '1)
      mispred_cnt <= mispred_cnt + 32'd1;
  end

endmodule

// File: tb/tb_branch_pc_predict.sv
// Scoreboard bench for branch_pc_predict: a bimodal and a static instance
// share stimulus; expectations are queued at drive time and popped at sample.
module tb_branch_pc_predict;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        f_valid;
  logic [3:0]  f_icode, f_ifun;
  logic [63:0] f_pc, f_valC, f_valP;
  logic        e_valid;
  logic [3:0]  e_icode, e_ifun;
  logic [63:0] e_pc;
  logic        e_taken, e_mispredict, ras_flush;

  logic [63:0] predPC, s_predPC;
  logic        pred_taken, s_pred_taken;
  logic        ras_empty_ret, s_ras_empty_ret;
  logic [31:0] mispred_cnt, s_mispred_cnt;

  always #5 clk = ~clk;

  branch_pc_predict #(.ADDR_W(64), .BHT_ENTRIES(16), .RAS_DEPTH(8), .PRED_MODE(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_pc(f_pc), .f_valC(f_valC), .f_valP(f_valP), .predPC(predPC),
    .pred_taken(pred_taken), .ras_empty_ret(ras_empty_ret), .e_valid(e_valid),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_pc(e_pc), .e_taken(e_taken),
    .e_mispredict(e_mispredict), .ras_flush(ras_flush), .mispred_cnt(mispred_cnt)
  );

  branch_pc_predict #(.ADDR_W(64), .BHT_ENTRIES(16), .RAS_DEPTH(8), .PRED_MODE(0)) u_static (
    .clk(clk), .rst_n(rst_n), .f_valid(f_valid), .f_icode(f_icode), .f_ifun(f_ifun),
    .f_pc(f_pc), .f_valC(f_valC), .f_valP(f_valP), .predPC(s_predPC),
    .pred_taken(s_pred_taken), .ras_empty_ret(s_ras_empty_ret), .e_valid(e_valid),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_pc(e_pc), .e_taken(e_taken),
    .e_mispredict(e_mispredict), .ras_flush(ras_flush), .mispred_cnt(s_mispred_cnt)
  );

  typedef struct {
    string       tag;
    logic [63:0] pc;
    logic        tk;
    logic        re;
    logic [63:0] spc;
    logic [31:0] mis;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mis_model = '0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Globals (rst_n, e_*, ras_flush) set before a step apply to that step's edge.
  task automatic step(input string tag, input logic fv, input logic [3:0] ic, input logic [3:0] ifn,
                      input logic [63:0] pc, input logic [63:0] vc, input logic [63:0] vp,
                      input logic [63:0] xpc, input logic xtk, input logic xre,
                      input logic [63:0] xspc);
    exp_t e;
    @(negedge clk);
    f_valid = fv; f_icode = ic; f_ifun = ifn; f_pc = pc; f_valC = vc; f_valP = vp;
    e.tag = tag; e.pc = xpc; e.tk = xtk; e.re = xre; e.spc = xspc; e.mis = mis_model;
    sb.push_back(e);
    #1;
    e = sb.pop_front();
    check_eq({e.tag, ".predPC"}, predPC, e.pc);
    check_eq({e.tag, ".taken"}, {63'd0, pred_taken}, {63'd0, e.tk});
    check_eq({e.tag, ".empty_ret"}, {63'd0, ras_empty_ret}, {63'd0, e.re});
    check_eq({e.tag, ".static_predPC"}, s_predPC, e.spc);
    check_eq({e.tag, ".mispred"}, {32'd0, mispred_cnt}, {32'd0, e.mis});
    check_eq({e.tag, ".static_mispred"}, {32'd0, s_mispred_cnt}, {32'd0, e.mis});
    if (!rst_n)
      mis_model = '0;
    else if (e_valid && e_mispredict && mis_model != 32'hffff_ffff)
      mis_model = mis_model + 32'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, I_NOP, 4'h0, 64'h0, 64'h0, 64'h33, 64'h33, 1'b0, 1'b0, 64'h33);
  endtask

  task automatic jcc(input string tag, input logic tk);
    step(tag, 1'b1, I_JXX, 4'h1, 64'h10, 64'h100, 64'h19,
         tk ? 64'h100 : 64'h19, tk, 1'b0, 64'h100);
  endtask

  task automatic call(input string tag, input logic [63:0] vp, input logic fv);
    step(tag, fv, I_CALL, 4'h0, 64'h0, 64'h800, vp, 64'h800, 1'b0, 1'b0, 64'h800);
  endtask

  task automatic ret(input string tag, input logic [63:0] xpc, input logic xre);
    step(tag, 1'b1, I_RET, 4'h0, 64'h0, 64'h999, 64'h1000, xpc, 1'b0, xre, xpc);
  endtask

  task automatic resolve(input logic v, input logic tk, input logic misp);
    e_valid = v; e_icode = I_JXX; e_ifun = 4'h1; e_pc = 64'h10;
    e_taken = tk; e_mispredict = misp;
  endtask

  initial begin
    rst_n = 1'b0; ras_flush = 1'b0;
    f_valid = 1'b0; f_icode = '0; f_ifun = '0; f_pc = '0; f_valC = '0; f_valP = '0;
    resolve(1'b0, 1'b0, 1'b0);

    idle("rst_idle");
    ret("rst_ret", 64'h1000, 1'b1);
    jcc("rst_jcc", 1'b1);
    rst_n = 1'b1;

    jcc("bht_init", 1'b1);
    resolve(1'b1, 1'b0, 1'b0);
    jcc("bht_nt1_old", 1'b1);
    jcc("bht_nt2_old", 1'b0);
    resolve(1'b0, 1'b0, 1'b0);
    jcc("bht_at0", 1'b0);
    resolve(1'b1, 1'b0, 1'b0);
    jcc("bht_nt3", 1'b0);
    resolve(1'b1, 1'b1, 1'b0);
    jcc("bht_t_same", 1'b0);
    resolve(1'b0, 1'b0, 1'b0);
    jcc("bht_at1", 1'b0);
    resolve(1'b1, 1'b1, 1'b0);
    jcc("bht_t2_same", 1'b0);
    resolve(1'b0, 1'b0, 1'b0);
    jcc("bht_at2", 1'b1);

    step("jmp", 1'b1, I_JXX, J_YES, 64'h10, 64'h300, 64'h19, 64'h300, 1'b1, 1'b0, 64'h300);
    step("halt", 1'b1, I_HALT, 4'h0, 64'h0, 64'h500, 64'h22, 64'h22, 1'b0, 1'b0, 64'h22);
    step("ic12", 1'b1, 4'hC, 4'h0, 64'h0, 64'h500, 64'h23, 64'h23, 1'b0, 1'b0, 64'h23);

    call("call20", 64'h20, 1'b1);
    call("call40", 64'h40, 1'b1);
    ret("ret40", 64'h40, 1'b0);
    ret("ret20", 64'h20, 1'b0);
    ret("ret_empty", 64'h1000, 1'b1);

    for (int i = 1; i <= 9; i++) call("call9", 64'(i), 1'b1);
    for (int i = 0; i < 8; i++) ret("ret9", 64'(9 - i), 1'b0);
    ret("ret9_empty", 64'h1000, 1'b1);

    call("fl_pre", 64'h60, 1'b1);
    ras_flush = 1'b1;
    call("fl_call", 64'h70, 1'b1);
    ras_flush = 1'b0;
    ret("fl_ret", 64'h1000, 1'b1);
    call("nv_call", 64'h80, 1'b0);
    ret("nv_ret", 64'h1000, 1'b1);

    resolve(1'b1, 1'b0, 1'b1);
    idle("mis1");
    idle("mis2");
    idle("mis3");
    resolve(1'b0, 1'b0, 1'b0);
    jcc("mis_lookup", 1'b0);
    rst_n = 1'b0;
    resolve(1'b1, 1'b1, 1'b1);
    idle("mid_rst");
    rst_n = 1'b1;
    resolve(1'b0, 1'b0, 1'b0);
    jcc("post_rst_jcc", 1'b1);
    ret("post_rst_ret", 64'h1000, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
